// File: rtl/serial_alu_seq_pkg.sv
// rtl/serial_alu_seq_pkg.sv - shared ALU control codes and FSM state encoding for serial_alu_seq
package serial_alu_seq_pkg;

    // alu_ctl = {ainvert, binvert, op[1:0]}
    localparam logic [3:0] ALU_CTL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTL_NOR = 4'b1100;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PASS1 = 2'b01,
        S_PASS2 = 2'b10,
        S_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/serial_alu_seq_slice.sv
// rtl/serial_alu_seq_slice.sv - my1BitALUv3 one-bit ALU slice (and/or/sum/less with operand inversion)
module my1BitALUv3
    import serial_alu_seq_pkg::*;
(
    input  logic       in1,
    input  logic       in2,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic       carryin,
    input  logic       less,
    input  logic [1:0] op,
    output logic       result,
    output logic       carryout
);

    logic a_eff;
    logic b_eff;

    // Operand inversion, full adder carry and the op multiplexer
    always_comb begin
        a_eff    = in1 ^ ainvert;
        b_eff    = in2 ^ binvert;
        carryout = (a_eff & b_eff) | (a_eff & carryin) | (b_eff & carryin);
        case (op)
            OP_AND:  result = a_eff & b_eff;
            OP_OR:   result = a_eff | b_eff;
            OP_SUM:  result = a_eff ^ b_eff ^ carryin;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// rtl/serial_alu_seq.sv - bit-serial word ALU around one my1BitALUv3 slice; SERIAL_ALU_SLT_EN enables signed SLT
module serial_alu_seq
    import serial_alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       ctl_q;
    logic [IW-1:0]    idx;
    logic             cy;
    logic             last;
    logic             is_less_op;
    logic             is_sum_op;
    logic [WIDTH-1:0] res_wr;

    logic       s_a;
    logic       s_b;
    logic       s_ainv;
    logic       s_binv;
    logic       s_cin;
    logic       s_less;
    logic [1:0] s_op;
    logic       s_res;
    logic       s_cout;

`ifdef SERIAL_ALU_SLT_EN
    logic cin_msb;
    logic cout_msb;
    logic sum_msb;
    logic slt_set;
`endif

    assign last       = (idx == LAST);
    assign is_less_op = (ctl_q[1:0] == OP_LESS);
    assign is_sum_op  = (ctl_q[1:0] == OP_SUM);

`ifdef SERIAL_ALU_SLT_EN
    // Signed a<b: sign of a-b corrected by signed overflow of that subtraction
    assign slt_set = sum_msb ^ cin_msb ^ cout_msb;
`endif

    // Slice operand selection; SLT first pass is forced into a subtraction
    always_comb begin
        s_a    = a_q[idx];
        s_b    = b_q[idx];
        s_ainv = ctl_q[3];
        s_binv = ctl_q[2];
        s_op   = ctl_q[1:0];
        s_cin  = cy;
        s_less = 1'b0;
`ifdef SERIAL_ALU_SLT_EN
        if (state == S_PASS1 && is_less_op) begin
            s_op   = OP_SUM;
            s_binv = 1'b1;
        end
        if (state == S_PASS2) begin
            s_less = (idx == '0) ? slt_set : 1'b0;
        end
`endif
    end

    my1BitALUv3 u_slice (
        .in1      (s_a),
        .in2      (s_b),
        .ainvert  (s_ainv),
        .binvert  (s_binv),
        .carryin  (s_cin),
        .less     (s_less),
        .op       (s_op),
        .result   (s_res),
        .carryout (s_cout)
    );

    // Current result word with this cycle's bit merged in
    always_comb begin
        res_wr      = result;
        res_wr[idx] = s_res;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_PASS1;
            S_PASS1: begin
                if (last) begin
`ifdef SERIAL_ALU_SLT_EN
                    state_nx = is_less_op ? S_PASS2 : S_DONE;
`else
                    state_nx = S_DONE;
`endif
                end
            end
            S_PASS2: begin
`ifdef SERIAL_ALU_SLT_EN
                if (last) state_nx = S_DONE;
`else
                state_nx = S_IDLE;
`endif
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        busy = (state == S_PASS1) || (state == S_PASS2);
        done = (state == S_DONE);
    end

    // Operand latch, bit index, carry chain and result/flag assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            ctl_q     <= '0;
            idx       <= '0;
            cy        <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
`ifdef SERIAL_ALU_SLT_EN
            cin_msb   <= 1'b0;
            cout_msb  <= 1'b0;
            sum_msb   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        ctl_q <= alu_ctl;
                        idx   <= '0;
`ifdef SERIAL_ALU_SLT_EN
                        cy    <= alu_ctl[2] | (alu_ctl[1:0] == OP_LESS);
`else
                        cy    <= alu_ctl[2];
`endif
                    end
                end
                S_PASS1: begin
                    result <= res_wr;
                    cy     <= s_cout;
                    idx    <= idx + 1'b1;
                    if (last) begin
                        idx       <= '0;
                        zero      <= (res_wr == '0);
                        carry_out <= is_sum_op & s_cout;
                        overflow  <= is_sum_op & (cy ^ s_cout);
`ifdef SERIAL_ALU_SLT_EN
                        cin_msb   <= cy;
                        cout_msb  <= s_cout;
                        sum_msb   <= s_res;
`endif
                    end
                end
`ifdef SERIAL_ALU_SLT_EN
                S_PASS2: begin
                    result <= res_wr;
                    idx    <= idx + 1'b1;
                    if (last) begin
                        idx  <= '0;
                        zero <= (res_wr == '0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb/tb_serial_alu_seq.sv - scoreboard testbench for serial_alu_seq
module tb_serial_alu_seq;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       v;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a_i = '0;
    logic [7:0] b_i = '0;
    logic [3:0] ctl_i = '0;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       zero;
    logic       carry_out;
    logic       overflow;

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    serial_alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a_i),
        .b         (b_i),
        .alu_ctl   (ctl_i),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] ctl);
        exp_t e;
        logic [7:0] ai;
        logic [7:0] bi;
        logic [8:0] s;
        ai = ctl[3] ? ~a : a;
        bi = ctl[2] ? ~b : b;
        s  = {1'b0, ai} + {1'b0, bi} + {8'd0, ctl[2]};
        e.c = 1'b0;
        e.v = 1'b0;
        e.lat = 9;
        case (ctl[1:0])
            2'b00: e.res = ai & bi;
            2'b01: e.res = ai | bi;
            2'b10: begin
                e.res = s[7:0];
                e.c   = s[8];
                e.v   = (ai[7] == bi[7]) && (s[7] != ai[7]);
            end
            default: begin
`ifdef SERIAL_ALU_SLT_EN
                e.res = ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
                e.lat = 17;
`else
                e.res = 8'h00;
`endif
            end
        endcase
        e.z = (e.res == 8'h00);
        return e;
    endfunction

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] ctl, input logic pulse_again);
        exp_t e;
        int   c0;
        int   d0;
        logic got;
        sb.push_back(model(a, b, ctl));
        d0 = done_cnt;
        @(negedge clk);
        a_i = a; b_i = b; ctl_i = ctl; start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/busy"}, 32'(busy), 32'd1);
        if (pulse_again) begin
            @(negedge clk);
            a_i = ~a; b_i = 8'h33; ctl_i = 4'b0001; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk({tag, "/done_seen"}, 32'(got), 32'd1);
        if (got) begin
            e = sb.pop_front();
            chk({tag, "/result"}, 32'(result), 32'(e.res));
            chk({tag, "/zero"}, 32'(zero), 32'(e.z));
            chk({tag, "/carry_out"}, 32'(carry_out), 32'(e.c));
            chk({tag, "/overflow"}, 32'(overflow), 32'(e.v));
            chk({tag, "/latency"}, 32'(cyc - c0), 32'(e.lat));
            chk({tag, "/busy_at_done"}, 32'(busy), 32'd0);
            @(negedge clk);
            chk({tag, "/done_pulse"}, 32'(done), 32'd0);
            repeat (3) @(negedge clk);
            chk({tag, "/done_count"}, 32'(done_cnt - d0), 32'd1);
        end else begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/done", 32'(done), 32'd0);
        chk("reset/result", 32'(result), 32'd0);
        chk("reset/zero", 32'(zero), 32'd0);
        chk("reset/carry_out", 32'(carry_out), 32'd0);
        chk("reset/overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        do_op("add_7f_01", 8'h7F, 8'h01, 4'b0010, 1'b0);
        do_op("sub_05_07", 8'h05, 8'h07, 4'b0110, 1'b0);
        do_op("sub_07_07", 8'h07, 8'h07, 4'b0110, 1'b0);
        do_op("nor_f0_0f", 8'hF0, 8'h0F, 4'b1100, 1'b0);
        do_op("and_f0_3c", 8'hF0, 8'h3C, 4'b0000, 1'b0);
        do_op("or_f0_3c",  8'hF0, 8'h3C, 4'b0001, 1'b0);
        do_op("slt_fd_02", 8'hFD, 8'h02, 4'b0111, 1'b0);
        do_op("slt_80_01", 8'h80, 8'h01, 4'b0111, 1'b0);
        do_op("slt_01_80", 8'h01, 8'h80, 4'b0111, 1'b0);
        do_op("add_ff_01", 8'hFF, 8'h01, 4'b0010, 1'b0);
        do_op("sub_80_01", 8'h80, 8'h01, 4'b0110, 1'b0);
        do_op("restart_ignored", 8'h12, 8'h34, 4'b0010, 1'b1);

        // Abort an ADD while bit 4 is being processed
        d0 = done_cnt;
        @(negedge clk);
        a_i = 8'h55; b_i = 8'h22; ctl_i = 4'b0010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort/busy", 32'(busy), 32'd0);
        chk("abort/result", 32'(result), 32'd0);
        chk("abort/done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort/no_done", 32'(done_cnt - d0), 32'd0);
        do_op("add_after_abort", 8'h55, 8'h22, 4'b0010, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [3:0] ctl_tab [6];
            ctl_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
            do_op($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), ctl_tab[i], 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
